// File: rtl/sonar_sample_sequencer_pkg.sv
// Shared definitions for the sonar sample sequencer: default sample geometry,
// sequencer state encoding and the bit layout of the classification result.
package sonar_sample_sequencer_pkg;

    localparam int N_FEAT_DEF = 60;
    localparam int FEAT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RESULT = 2'd2
    } seq_state_e;

    // res_class = {indikator_2, indikator_1}
    localparam int RES_IND1_BIT = 0;
    localparam int RES_IND2_BIT = 1;

endpackage

// File: rtl/sonar_sample_sequencer_packer.sv
// Feature packer: tracks the feature index of the sample being loaded and
// writes each accepted beat into its slot of the packed uzorak vector.
// Feature k occupies uzorak[k*FEAT_W +: FEAT_W].
module sonar_feature_packer #(
    parameter int N_FEAT = 60,
    parameter int FEAT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     beat_i,
    input  logic [FEAT_W-1:0]        data_i,
    input  logic                     last_i,
    output logic [N_FEAT*FEAT_W-1:0] uzorak_o,
    output logic                     early_last_o,
    output logic                     sample_done_o
);

    localparam int IDX_W = $clog2(N_FEAT);

    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N_FEAT*FEAT_W-1:0] uzorak_q, uzorak_d;
    logic                    at_end;

    assign at_end        = (idx_q == IDX_W'(N_FEAT - 1));
    // An early feat_last drops the sample; the final slot completes it
    // whether or not feat_last came with it.
    assign early_last_o  = beat_i && last_i && !at_end;
    assign sample_done_o = beat_i && at_end;
    assign uzorak_o      = uzorak_q;

    // Index advance and slot write for each accepted beat
    always_comb begin
        idx_d    = idx_q;
        uzorak_d = uzorak_q;
        if (beat_i) begin
            if (at_end) begin
                uzorak_d[int'(idx_q)*FEAT_W +: FEAT_W] = data_i;
                idx_d = '0;
            end else if (last_i) begin
                idx_d = '0;
            end else begin
                uzorak_d[int'(idx_q)*FEAT_W +: FEAT_W] = data_i;
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Index and sample storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            uzorak_q <= '0;
        end else begin
            idx_q    <= idx_d;
            uzorak_q <= uzorak_d;
        end
    end

endmodule

// File: rtl/sonar_sample_sequencer.sv
// Sonar sample sequencer: loads 60 features into the classifier input vector,
// freezes it while the core settles, then offers the captured indikator pair
// as one result.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both 1; valid, once raised, holds with its payload stable until that edge.
module sonar_sample_sequencer
    import sonar_sample_sequencer_pkg::*;
#(
    parameter int N_FEAT      = N_FEAT_DEF,
    parameter int FEAT_W      = FEAT_W_DEF,
    parameter int NET_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     feat_valid,
    input  logic [FEAT_W-1:0]        feat_data,
    input  logic                     feat_last,
    output logic                     feat_ready,
    output logic [N_FEAT*FEAT_W-1:0] uzorak,
    input  logic                     indikator_1,
    input  logic                     indikator_2,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [1:0]               res_class,
    output logic                     res_err,
    output logic                     err_pulse,
    output logic [CNT_W-1:0]         res_count,
    output logic [1:0]               dbg_state
);

    seq_state_e       state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic             missing_q, missing_d;
    logic             feat_ready_q, feat_ready_d;
    logic             res_valid_q, res_valid_d;
    logic [1:0]       res_class_q, res_class_d;
    logic             res_err_q, res_err_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;

    logic beat;
    logic early_last;
    logic sample_done;

    // feat_ready_q is only 1 in LOAD, so this is the accept condition
    assign beat = feat_valid && feat_ready_q;

    sonar_feature_packer #(
        .N_FEAT (N_FEAT),
        .FEAT_W (FEAT_W)
    ) u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .beat_i        (beat),
        .data_i        (feat_data),
        .last_i        (feat_last),
        .uzorak_o      (uzorak),
        .early_last_o  (early_last),
        .sample_done_o (sample_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_LOAD;
        else        state_q <= state_d;
    end

    // Next-state: the wait counter runs NET_LATENCY down to 0, giving the core
    // NET_LATENCY+1 cycles between the final write and the indikator sample
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:   if (sample_done)   state_d = ST_WAIT;
            ST_WAIT:   if (wait_q == '0)  state_d = ST_RESULT;
            ST_RESULT: if (res_ready)     state_d = ST_LOAD;
            default:                      state_d = ST_LOAD;
        endcase
    end

    // Output and datapath next values; ready/valid are registered from state_d
    always_comb begin
        wait_d      = wait_q;
        missing_d   = missing_q;
        res_class_d = res_class_q;
        res_err_d   = res_err_q;
        res_count_d = res_count_q;
        err_pulse_d = early_last;
        if (state_q == ST_LOAD && sample_done) begin
            wait_d    = 4'(NET_LATENCY);
            missing_d = !feat_last;
        end
        if (state_q == ST_WAIT) begin
            if (wait_q != '0) begin
                wait_d = wait_q - 4'd1;
            end else begin
                res_class_d[RES_IND1_BIT] = indikator_1;
                res_class_d[RES_IND2_BIT] = indikator_2;
                res_err_d                 = missing_q;
            end
        end
        if (state_q == ST_RESULT && res_ready) begin
            res_count_d = res_count_q + CNT_W'(1);
        end
        feat_ready_d = (state_d == ST_LOAD);
        res_valid_d  = (state_d == ST_RESULT);
    end

    // Registered outputs, wait counter and missing-last flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q       <= '0;
            missing_q    <= 1'b0;
            feat_ready_q <= 1'b1;
            res_valid_q  <= 1'b0;
            res_class_q  <= '0;
            res_err_q    <= 1'b0;
            err_pulse_q  <= 1'b0;
            res_count_q  <= '0;
        end else begin
            wait_q       <= wait_d;
            missing_q    <= missing_d;
            feat_ready_q <= feat_ready_d;
            res_valid_q  <= res_valid_d;
            res_class_q  <= res_class_d;
            res_err_q    <= res_err_d;
            err_pulse_q  <= err_pulse_d;
            res_count_q  <= res_count_d;
        end
    end

    assign feat_ready = feat_ready_q;
    assign res_valid  = res_valid_q;
    assign res_class  = res_class_q;
    assign res_err    = res_err_q;
    assign err_pulse  = err_pulse_q;
    assign res_count  = res_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sonar_sample_sequencer.sv
// Bench for sonar_sample_sequencer: drives feature samples, stubs the
// classifier core's indikator outputs and checks against a feature-array model.
module tb_sonar_sample_sequencer;

    localparam int N  = 60;
    localparam int W  = 16;
    localparam int LAT = 4;

    logic           clk;
    logic           rst_n;
    logic           feat_valid;
    logic [W-1:0]   feat_data;
    logic           feat_last;
    logic           feat_ready;
    logic [N*W-1:0] uzorak;
    logic           indikator_1;
    logic           indikator_2;
    logic           res_valid;
    logic           res_ready;
    logic [1:0]     res_class;
    logic           res_err;
    logic           err_pulse;
    logic [15:0]    res_count;
    logic [1:0]     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [W-1:0] model_feat [N];
    int           m_idx;
    bit           exp_missing;
    logic [15:0]  exp_count;
    logic [2:0]   exp_q [$];

    sonar_sample_sequencer #(
        .N_FEAT(N), .FEAT_W(W), .NET_LATENCY(LAT), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .feat_valid(feat_valid), .feat_data(feat_data), .feat_last(feat_last),
        .feat_ready(feat_ready), .uzorak(uzorak),
        .indikator_1(indikator_1), .indikator_2(indikator_2),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
        .res_err(res_err), .err_pulse(err_pulse), .res_count(res_count),
        .dbg_state(dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] pack_model();
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*W +: W] = model_feat[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) model_feat[i] = '0;
        m_idx     = 0;
        exp_count = '0;
        exp_q.delete();
    endtask

    // Drives n beats starting at a negedge; beat last_at carries feat_last
    // (-1: none). Returns at the negedge right after the last accept edge.
    task automatic send_sample(input int n, input int last_at, input bit gappy, input bit seq_data);
        logic [W-1:0] d;
        for (int k = 0; k < n; k++) begin
            if (gappy) begin
                feat_valid = 1'b0;
                @(negedge clk);
            end
            n_checks++;
            if (feat_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_ready beat %0d: got %b expected 1", k, feat_ready);
            end
            d = seq_data ? W'(k + 1) : W'($urandom);
            feat_valid = 1'b1;
            feat_data  = d;
            feat_last  = (k == last_at);
            @(posedge clk);
            if (k == last_at && m_idx != N - 1) begin
                m_idx = 0;
            end else begin
                model_feat[m_idx] = d;
                if (m_idx == N - 1) begin
                    m_idx       = 0;
                    exp_missing = (k != last_at);
                end else begin
                    m_idx++;
                end
            end
            @(negedge clk);
        end
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    // Called at the negedge following the final accept of a full sample.
    task automatic check_result(input logic [1:0] cls, input int hold);
        logic [2:0]     exp;
        logic [1:0]     held_cls;
        logic [N*W-1:0] exp_uz;
        exp_q.push_back({exp_missing, cls});
        indikator_2 = cls[1];
        indikator_1 = cls[0];
        exp_uz = pack_model();
        for (int k = 1; k <= LAT + 1; k++) begin
            n_checks++;
            if (res_valid !== 1'b0 || feat_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_outputs cycle %0d: valid=%b ready=%b expected 0/0", k, res_valid, feat_ready);
            end
            if (k == 1) begin
                n_checks++;
                if (uzorak !== exp_uz) begin
                    n_fail++;
                    $display("FAIL uzorak_packed: got %h expected %h", uzorak, exp_uz);
                end
            end
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL res_valid_rise: got %b expected 1", res_valid);
        end
        n_checks++;
        if (res_class !== exp[1:0] || res_err !== exp[2]) begin
            n_fail++;
            $display("FAIL res_payload: got class=%b err=%b expected class=%b err=%b",
                     res_class, res_err, exp[1:0], exp[2]);
        end
        held_cls = exp[1:0];
        for (int h = 0; h < hold; h++) begin
            indikator_1 = ~indikator_1;
            indikator_2 = 1'($urandom);
            feat_valid  = 1'b1;
            feat_data   = W'($urandom);
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_class !== held_cls || feat_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL result_hold %0d: valid=%b class=%b ready=%b expected 1/%b/0",
                         h, res_valid, res_class, feat_ready, held_cls);
            end
        end
        feat_valid = 1'b0;
        res_ready  = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        n_checks++;
        if (res_valid !== 1'b0 || feat_ready !== 1'b1 || res_count !== exp_count) begin
            n_fail++;
            $display("FAIL handshake: valid=%b ready=%b count=%0d expected 0/1/%0d",
                     res_valid, feat_ready, res_count, exp_count);
        end
        n_checks++;
        if (uzorak !== exp_uz) begin
            n_fail++;
            $display("FAIL uzorak_after_result: got %h expected %h", uzorak, exp_uz);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; feat_valid = 1'b0; feat_data = '0; feat_last = 1'b0;
        indikator_1 = 1'b0; indikator_2 = 1'b0; res_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        n_checks++;
        if (feat_ready !== 1'b1 || res_valid !== 1'b0 || res_class !== 2'b00 || res_err !== 1'b0
            || err_pulse !== 1'b0 || res_count !== 16'd0 || uzorak !== '0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_values: ready=%b valid=%b class=%b err=%b pulse=%b count=%0d state=%0d",
                     feat_ready, res_valid, res_class, res_err, err_pulse, res_count, dbg_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send_sample(N, N - 1, 1'b0, 1'b1);
        n_checks++;
        if (uzorak[15:0] !== 16'd1 || uzorak[959:944] !== 16'd60) begin
            n_fail++;
            $display("FAIL basic_ends: got first=%0d last=%0d expected 1/60", uzorak[15:0], uzorak[959:944]);
        end
        check_result(2'b01, 0);
    endtask

    task automatic test_early_last();
        send_sample(11, 10, 1'b0, 1'b0);
        n_checks++;
        if (err_pulse !== 1'b1 || feat_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL early_pulse: pulse=%b ready=%b expected 1/1", err_pulse, feat_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (err_pulse !== 1'b0 || res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL early_after %0d: pulse=%b valid=%b expected 0/0", i, err_pulse, res_valid);
            end
        end
        send_sample(N, N - 1, 1'b0, 1'b0);
        check_result(2'b10, 0);
    endtask

    task automatic test_missing_last();
        send_sample(N, -1, 1'b0, 1'b0);
        check_result(2'b11, 1);
        send_sample(N, N - 1, 1'b0, 1'b0);
        check_result(2'b00, 0);
    endtask

    task automatic test_back_pressure();
        send_sample(N, N - 1, 1'b0, 1'b0);
        check_result(2'b10, 6);
    endtask

    task automatic test_reset_mid_wait();
        send_sample(N, N - 1, 1'b0, 1'b0);
        indikator_1 = 1'b1; indikator_2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (feat_ready !== 1'b1 || res_valid !== 1'b0 || res_class !== 2'b00 || res_err !== 1'b0
            || res_count !== 16'd0 || uzorak !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: ready=%b valid=%b class=%b err=%b count=%0d",
                     feat_ready, res_valid, res_class, res_err, res_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b0 || feat_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL after_reset %0d: valid=%b ready=%b expected 0/1", i, res_valid, feat_ready);
            end
        end
        send_sample(N, N - 1, 1'b0, 1'b0);
        check_result(2'b01, 0);
    endtask

    task automatic test_gapped();
        send_sample(N, N - 1, 1'b1, 1'b1);
        check_result(2'b11, 2);
    endtask

    task automatic test_random();
        int last_at;
        for (int s = 0; s < 5; s++) begin
            last_at = ($urandom_range(0, 3) == 0) ? -1 : N - 1;
            send_sample(N, last_at, 1'($urandom_range(0, 1)), 1'b0);
            check_result(2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early_last();
        test_missing_last();
        test_back_pressure();
        test_reset_mid_wait();
        test_gapped();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
